// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM state type and the byte-strobe helper
// used by the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RAW_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [3:0] byte_strobes(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Single-port MEM_WORDS x 32 SRAM with per-byte write enables and a registered
// read port; no reset on storage or output so it maps onto block RAM.
module ahb_sram_array #(
  parameter int MEM_WORDS = 16384
) (
  input  logic                         clk_sys,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [3:0]                   we,
  input  logic [31:0]                  wdata,
  input  logic                         re,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk_sys) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite slave in front of a byte-writable SRAM: zero-wait pipelined reads and
// writes, one stall on read-after-write port conflicts, two-cycle ERROR otherwise.
//
// state       | meaning
// ST_IDLE     | no pending data phase
// ST_WR_DATA  | write data phase, SRAM write issued this cycle
// ST_RD_DATA  | read data phase, HRDATA taken from SRAM output
// ST_RAW_WAIT | read held one cycle while the preceding write used the port
// ST_ERR1     | first ERROR cycle (HREADYOUT low)
// ST_ERR2     | second ERROR cycle (HREADYOUT high)
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int ADDR_W    = 32
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic [1:0]        HRESP
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int BYTE_AW = IDX_W + 2;

  state_e state, state_nxt;

  logic             accept, legal, size_ok, aligned, in_range, rd_accept;
  logic [IDX_W-1:0] addr_idx, wr_idx, raw_idx, ram_addr;
  logic [3:0]       wr_strb, ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata, rdata_hold;
  logic             unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign accept   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign size_ok  = (HSIZE == HSIZE_BYTE) | (HSIZE == HSIZE_HALF) | (HSIZE == HSIZE_WORD);
  assign in_range = (HADDR >> BYTE_AW) == '0;
  assign legal    = size_ok & aligned & in_range;
  assign addr_idx = HADDR[BYTE_AW-1:2];
  assign rd_accept = accept & legal & ~HWRITE;

  always_comb begin
    aligned = 1'b1;
    if (HSIZE == HSIZE_HALF)      aligned = ~HADDR[0];
    else if (HSIZE == HSIZE_WORD) aligned = (HADDR[1:0] == 2'b00);
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RAW_WAIT: state_nxt = ST_RD_DATA;
      ST_ERR1:     state_nxt = ST_ERR2;
      default: begin
        if (accept) begin
          if (!legal)                  state_nxt = ST_ERR1;
          else if (HWRITE)             state_nxt = ST_WR_DATA;
          else if (state == ST_WR_DATA) state_nxt = ST_RAW_WAIT;
          else                         state_nxt = ST_RD_DATA;
        end
      end
    endcase
  end

  // The SRAM port is shared: a write owns it in WR_DATA, a stalled read in RAW_WAIT,
  // otherwise a newly accepted read is issued straight from the address phase.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = rdata_hold;
    ram_we    = 4'b0000;
    ram_re    = 1'b0;
    ram_addr  = addr_idx;
    case (state)
      ST_WR_DATA: begin
        ram_we   = wr_strb;
        ram_addr = wr_idx;
      end
      ST_RAW_WAIT: begin
        HREADYOUT = 1'b0;
        ram_re    = 1'b1;
        ram_addr  = raw_idx;
      end
      ST_RD_DATA: begin
        HRDATA = ram_rdata;
        ram_re = rd_accept;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        HRESP  = HRESP_ERROR;
        ram_re = rd_accept;
      end
      default: ram_re = rd_accept;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      wr_idx     <= '0;
      wr_strb    <= 4'b0000;
      raw_idx    <= '0;
      rdata_hold <= '0;
    end else begin
      if (accept & legal & HWRITE) begin
        wr_idx  <= addr_idx;
        wr_strb <= byte_strobes(HSIZE, HADDR[1:0]);
      end
      if ((state == ST_WR_DATA) & rd_accept) raw_idx <= addr_idx;
      if (state == ST_RD_DATA) rdata_hold <= ram_rdata;
    end
  end

  ahb_sram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk_sys (HCLK),
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (HWDATA),
    .re      (ram_re),
    .rdata   (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: directed scenarios and random traffic compared
// against a byte-addressed memory model and per-transfer response rules.
`timescale 1ns/1ps
module tb_ahb_sram_responder;
  import ahb_pkg::*;

  localparam int MEM_WORDS = 16384;
  localparam int MEM_BYTES = 4 * MEM_WORDS;
  localparam int MAXQ      = 64;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = '0, HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic        HREADY, HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_sram_responder #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       xq[$];
  logic [31:0] r_rdata [MAXQ];
  logic [1:0]  r_resp  [MAXQ];
  logic [1:0]  r_wresp [MAXQ];
  int          r_stalls[MAXQ];
  logic [31:0] e_rdata [MAXQ];
  logic [31:0] e_mask  [MAXQ];
  logic [1:0]  e_resp  [MAXQ];
  int          e_stalls[MAXQ];
  logic [7:0]  mem_b [logic [31:0]];
  int checks = 0, failures = 0, run_cycles = 0;
  bit run_timeout = 1'b0;

  function automatic xfer_t mk(logic [1:0] t, logic w, logic [2:0] s, logic [31:0] a, logic [31:0] d);
    xfer_t x;
    x.trans = t; x.write = w; x.size = s; x.addr = a; x.wdata = d;
    return x;
  endfunction

  function automatic bit is_active(xfer_t x);
    return (x.trans == HTRANS_NONSEQ) || (x.trans == HTRANS_SEQ);
  endfunction

  function automatic bit is_legal(xfer_t x);
    if (x.size > 3'd2) return 1'b0;
    if ((x.addr % (32'd1 << x.size)) != 32'd0) return 1'b0;
    return x.addr < MEM_BYTES;
  endfunction

  // Reference model: walks the transfer list in program order, updating a byte memory.
  task automatic build_expect();
    for (int i = 0; i < xq.size(); i++) begin
      xfer_t x = xq[i];
      int nbytes = 1 << x.size;
      e_rdata[i] = '0; e_mask[i] = '0; e_resp[i] = HRESP_OKAY; e_stalls[i] = 0;
      if (!is_active(x)) continue;
      if (!is_legal(x)) begin
        e_resp[i] = HRESP_ERROR; e_stalls[i] = 1;
        continue;
      end
      if (!x.write && i > 0 && is_active(xq[i-1]) && is_legal(xq[i-1]) && xq[i-1].write)
        e_stalls[i] = 1;
      for (int k = 0; k < nbytes; k++) begin
        logic [31:0] ba = x.addr + 32'(k);
        int lane = int'(ba[1:0]);
        if (x.write) mem_b[ba] = x.wdata[8*lane +: 8];
        else if (mem_b.exists(ba)) begin
          e_rdata[i][8*lane +: 8] = mem_b[ba];
          e_mask[i][8*lane +: 8]  = 8'hFF;
        end
      end
    end
  endtask

  // Pipelined master: drives xq back to back, records each beat's data-phase response.
  task automatic ahb_run();
    int ai = 0, di = -1, n = xq.size(), guard = 0;
    for (int k = 0; k < n; k++) begin
      r_rdata[k] = 'x; r_resp[k] = 'x; r_wresp[k] = 'x; r_stalls[k] = 0;
    end
    run_cycles = 0;
    while ((ai < n || di >= 0) && guard < 400) begin
      @(posedge HCLK); #1;
      if (ai < n) begin
        HSEL = 1'b1; HTRANS = xq[ai].trans; HWRITE = xq[ai].write;
        HSIZE = xq[ai].size; HADDR = xq[ai].addr;
      end else begin
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
      end
      if (di >= 0) HWDATA = xq[di].wdata;
      @(negedge HCLK);
      guard++; run_cycles++;
      if (di >= 0) begin
        if (HREADYOUT) begin
          r_rdata[di] = HRDATA; r_resp[di] = HRESP;
        end else begin
          r_stalls[di]++; r_wresp[di] = HRESP;
        end
      end
      if (HREADYOUT) begin
        di = (ai < n) ? ai : -1;
        if (ai < n) ai++;
      end
    end
    run_timeout = (guard >= 400);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_hreadyout got=%b exp=1", HREADYOUT); end
    checks++; if (HRESP !== HRESP_OKAY) begin failures++; $display("FAIL rst_hresp got=%b exp=00", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
    @(negedge HCLK); HRESETN = 1'b1;
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL post_rst_hreadyout got=%b exp=1", HREADYOUT); end
    checks++; if (HRESP !== HRESP_OKAY) begin failures++; $display("FAIL post_rst_hresp got=%b exp=00", HRESP); end
  endtask

  task automatic test_write_read();
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL wr_rd_timeout cycles=%0d", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_resp[i] !== e_resp[i]) begin failures++; $display("FAIL wr_rd_resp[%0d] got=%b exp=%b", i, r_resp[i], e_resp[i]); end
      checks++; if (r_stalls[i] !== e_stalls[i]) begin failures++; $display("FAIL wr_rd_stalls[%0d] got=%0d exp=%0d", i, r_stalls[i], e_stalls[i]); end
    end
    checks++; if (r_rdata[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=deadbeef", r_rdata[1]); end
    checks++; if (r_stalls[1] !== 1) begin failures++; $display("FAIL wr_rd_raw_stall got=%0d exp=1", r_stalls[1]); end
  endtask

  task automatic test_byte_lanes();
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h20, 32'h11111111));
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21, 32'h22222222));
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h22, 32'h55665566));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL lanes_timeout cycles=%0d", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_resp[i] !== e_resp[i]) begin failures++; $display("FAIL lanes_resp[%0d] got=%b exp=%b", i, r_resp[i], e_resp[i]); end
      checks++; if (r_stalls[i] !== e_stalls[i]) begin failures++; $display("FAIL lanes_stalls[%0d] got=%0d exp=%0d", i, r_stalls[i], e_stalls[i]); end
    end
    checks++; if (r_rdata[3] !== 32'h55662211) begin failures++; $display("FAIL lanes_data got=%h exp=55662211", r_rdata[3]); end
  endtask

  task automatic test_burst();
    xq.delete();
    for (int i = 0; i < 8; i++)
      xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h100 + 32'(4*i), $urandom()));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL burst_preload_timeout cycles=%0d", run_cycles); end
    xq.delete();
    for (int i = 0; i < 8; i++)
      xq.push_back(mk(i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 0, HSIZE_WORD, 32'h100 + 32'(4*i), 32'h0));
    HBURST = 3'b101;
    build_expect(); ahb_run();
    HBURST = 3'b000;
    checks++; if (run_cycles !== 9) begin failures++; $display("FAIL burst_cycles got=%0d exp=9", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_stalls[i] !== 0) begin failures++; $display("FAIL burst_stalls[%0d] got=%0d exp=0", i, r_stalls[i]); end
      checks++; if (r_resp[i] !== HRESP_OKAY) begin failures++; $display("FAIL burst_resp[%0d] got=%b exp=00", i, r_resp[i]); end
      checks++; if (r_rdata[i] !== e_rdata[i]) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, r_rdata[i], e_rdata[i]); end
    end
  endtask

  task automatic test_errors();
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0, 32'h12345678));
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h2, 32'hFFFFFFFF));
    xq.push_back(mk(HTRANS_NONSEQ, 1, 3'b011, 32'h0, 32'hEEEEEEEE));
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(MEM_BYTES), 32'hCCCCCCCC));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h1, 32'h0));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL err_timeout cycles=%0d", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_resp[i] !== e_resp[i]) begin failures++; $display("FAIL err_resp[%0d] got=%b exp=%b", i, r_resp[i], e_resp[i]); end
      checks++; if (r_stalls[i] !== e_stalls[i]) begin failures++; $display("FAIL err_stalls[%0d] got=%0d exp=%0d", i, r_stalls[i], e_stalls[i]); end
      if (e_resp[i] == HRESP_ERROR) begin
        checks++; if (r_wresp[i] !== HRESP_ERROR) begin failures++; $display("FAIL err_first_cycle_resp[%0d] got=%b exp=01", i, r_wresp[i]); end
      end
    end
    checks++; if (r_rdata[5] !== 32'h12345678) begin failures++; $display("FAIL err_mem_unchanged got=%h exp=12345678", r_rdata[5]); end
  endtask

  task automatic test_raw_neighbour();
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h44, 32'h0BADF00D));
    xq.push_back(mk(HTRANS_IDLE,   0, HSIZE_BYTE, 32'h0,  32'h0));
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'hA5A5A5A5));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h44, 32'h0));
    xq.push_back(mk(HTRANS_SEQ,    0, HSIZE_WORD, 32'h40, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL raw_timeout cycles=%0d", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_resp[i] !== e_resp[i]) begin failures++; $display("FAIL raw_resp[%0d] got=%b exp=%b", i, r_resp[i], e_resp[i]); end
      checks++; if (r_stalls[i] !== e_stalls[i]) begin failures++; $display("FAIL raw_stalls[%0d] got=%0d exp=%0d", i, r_stalls[i], e_stalls[i]); end
    end
    checks++; if (r_rdata[3] !== 32'h0BADF00D) begin failures++; $display("FAIL raw_data44 got=%h exp=0badf00d", r_rdata[3]); end
    checks++; if (r_rdata[4] !== 32'hA5A5A5A5) begin failures++; $display("FAIL raw_data40 got=%h exp=a5a5a5a5", r_rdata[4]); end
  endtask

  task automatic test_random();
    xq.delete();
    for (int i = 0; i < 16; i++)
      xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h200 + 32'(4*i), $urandom()));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL rand_preload_timeout cycles=%0d", run_cycles); end
    xq.delete();
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(99);
      int r = $urandom_range(19);
      logic [1:0] t = (sel < 8) ? HTRANS_IDLE : (sel < 12) ? HTRANS_BUSY : (sel < 55) ? HTRANS_NONSEQ : HTRANS_SEQ;
      logic [2:0] s = ($urandom_range(19) == 0) ? 3'b011 : 3'($urandom_range(2));
      logic [31:0] a = 32'h200 + 32'($urandom_range(63));
      if (r == 0) a = 32'(MEM_BYTES) + (32'($urandom_range(15)) << 2);
      else if (r > 1) a = a & ~((32'd1 << s) - 32'd1);
      xq.push_back(mk(t, 1'($urandom_range(1)), s, a, $urandom()));
    end
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL rand_timeout cycles=%0d", run_cycles); end
    for (int i = 0; i < xq.size(); i++) begin
      checks++; if (r_resp[i] !== e_resp[i]) begin failures++; $display("FAIL rand_resp[%0d] got=%b exp=%b addr=%h", i, r_resp[i], e_resp[i], xq[i].addr); end
      checks++; if (r_stalls[i] !== e_stalls[i]) begin failures++; $display("FAIL rand_stalls[%0d] got=%0d exp=%0d", i, r_stalls[i], e_stalls[i]); end
      if (e_mask[i] != 32'h0) begin
        checks++; if ((r_rdata[i] & e_mask[i]) !== e_rdata[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h mask=%h", i, r_rdata[i], e_rdata[i], e_mask[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    // reset while in the first ERROR cycle
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HADDR = 32'h2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    checks++; if (HREADYOUT !== 1'b0 || HRESP !== HRESP_ERROR) begin failures++; $display("FAIL rst_err1_entry got=%b/%b exp=0/01", HREADYOUT, HRESP); end
    HRESETN = 1'b0; #1;
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_err1_hreadyout got=%b exp=1", HREADYOUT); end
    checks++; if (HRESP !== HRESP_OKAY) begin failures++; $display("FAIL rst_err1_hresp got=%b exp=00", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_err1_hrdata got=%h exp=0", HRDATA); end
    @(negedge HCLK); HRESETN = 1'b1;
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h84, 32'h600DCAFE));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h84, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL rst_after_timeout cycles=%0d", run_cycles); end
    checks++; if (r_rdata[1] !== 32'h600DCAFE || r_resp[1] !== HRESP_OKAY) begin failures++; $display("FAIL rst_after_read got=%h/%b exp=600dcafe/00", r_rdata[1], r_resp[1]); end
    // reset while in the read-after-write stall
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HADDR = 32'h80;
    @(posedge HCLK); #1;
    HWRITE = 1'b0; HWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    checks++; if (HREADYOUT !== 1'b0 || HRESP !== HRESP_OKAY) begin failures++; $display("FAIL rst_raw_entry got=%b/%b exp=0/00", HREADYOUT, HRESP); end
    HRESETN = 1'b0; #1;
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_raw_hreadyout got=%b exp=1", HREADYOUT); end
    checks++; if (HRESP !== HRESP_OKAY) begin failures++; $display("FAIL rst_raw_hresp got=%b exp=00", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_raw_hrdata got=%h exp=0", HRDATA); end
    @(negedge HCLK); HRESETN = 1'b1;
    for (int k = 0; k < 4; k++) mem_b.delete(32'h80 + 32'(k));
    xq.delete();
    xq.push_back(mk(HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h8A, 32'h7E570000));
    xq.push_back(mk(HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h8A, 32'h0));
    build_expect(); ahb_run();
    checks++; if (run_timeout) begin failures++; $display("FAIL rst_raw_after_timeout cycles=%0d", run_cycles); end
    checks++; if (r_rdata[1][31:16] !== 16'h7E57 || r_stalls[1] !== 1) begin failures++; $display("FAIL rst_raw_after_read got=%h stalls=%0d exp=7e57 stalls=1", r_rdata[1][31:16], r_stalls[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge HCLK);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_burst();
    test_errors();
    test_raw_neighbour();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
